// File: rtl/bank_axi3_defs.sv
// Shared constants, state encodings and request checks for the bank AXI3 memory slave.
package bank_axi3_defs;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_32B    = 3'b101;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    // Only full-line INCR bursts are served; anything else errors the whole burst.
    function automatic logic req_error(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_32B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/bank_axi3_mem_array.sv
// Line-granular storage: byte-strobed synchronous write, combinational read
// that the parent registers into its read-data holding register.
module bank_axi3_mem_array #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned MEM_AW     = 6
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [MEM_AW-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic [MEM_AW-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [1 << MEM_AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bank_axi3_mem_slave.sv
// AXI3 responder backed by a line-granular memory; independent read and write
// engines, one outstanding transaction per direction, INCR bursts of 1-16 beats.
module bank_axi3_mem_slave
    import bank_axi3_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned MEM_AW     = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [2:0]            s_arsize_i,
    input  logic [3:0]            s_arlen_i,
    input  logic [1:0]            s_arburst_i,

    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rlast_o,

    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [ID_WIDTH-1:0]   s_awid_i,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic [2:0]            s_awsize_i,
    input  logic [3:0]            s_awlen_i,
    input  logic [1:0]            s_awburst_i,

    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    input  logic [ID_WIDTH-1:0]   s_wid_i,
    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    input  logic [STRB_WIDTH-1:0] s_wstrb_i,
    input  logic                  s_wlast_i,

    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    output logic [ID_WIDTH-1:0]   s_bid_o,
    output logic [1:0]            s_bresp_o
);

    rd_state_e             rd_state_q;
    logic                  arready_q, rvalid_q, rlast_q, rd_err_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [MEM_AW-1:0]     rd_idx_q;
    logic [3:0]            rd_len_q, rd_cnt_q;

    wr_state_e             wr_state_q;
    logic                  awready_q, wready_q, bvalid_q, wr_err_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;
    logic [MEM_AW-1:0]     wr_idx_q;
    logic [3:0]            wr_len_q, wr_cnt_q;

    logic [MEM_AW-1:0]     ar_idx, aw_idx, rd_idx_nxt, mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  ar_err, aw_err, w_last_exp, w_err, mem_we;
    logic                  unused_ok;

    assign ar_idx     = s_araddr_i[5+MEM_AW-1:5];
    assign aw_idx     = s_awaddr_i[5+MEM_AW-1:5];
    assign ar_err     = req_error(s_arsize_i, s_arburst_i);
    assign aw_err     = req_error(s_awsize_i, s_awburst_i);
    assign rd_idx_nxt = rd_idx_q + MEM_AW'(1);
    // Idle reads the line being requested; mid-burst prefetches the next beat.
    assign mem_raddr  = (rd_state_q == RD_IDLE) ? ar_idx : rd_idx_nxt;

    assign w_last_exp = (wr_cnt_q == wr_len_q);
    assign w_err      = wr_err_q | (s_wlast_i != w_last_exp);
    assign mem_we     = wready_q & s_wvalid_i & ~w_err;

    assign unused_ok = ^{s_araddr_i[ADDR_WIDTH-1:5+MEM_AW], s_araddr_i[4:0],
                         s_awaddr_i[ADDR_WIDTH-1:5+MEM_AW], s_awaddr_i[4:0], s_wid_i};

    bank_axi3_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .MEM_AW    (MEM_AW)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .waddr_i(wr_idx_q),
        .wdata_i(s_wdata_i),
        .wstrb_i(s_wstrb_i),
        .raddr_i(mem_raddr),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rd_err_q   <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (s_arvalid_i) begin
                        rd_state_q <= RD_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rid_q      <= s_arid_i;
                        rd_idx_q   <= ar_idx;
                        rd_len_q   <= s_arlen_i;
                        rd_cnt_q   <= '0;
                        rd_err_q   <= ar_err;
                        rresp_q    <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        rdata_q    <= ar_err ? '0 : mem_rdata;
                        rlast_q    <= (s_arlen_i == 4'd0);
                    end
                end
                RD_DATA: begin
                    if (s_rready_i) begin
                        if (rlast_q) begin
                            rd_state_q <= RD_IDLE;
                            arready_q  <= 1'b1;
                            rvalid_q   <= 1'b0;
                            rlast_q    <= 1'b0;
                        end else begin
                            rd_idx_q <= rd_idx_nxt;
                            rd_cnt_q <= rd_cnt_q + 4'd1;
                            rdata_q  <= rd_err_q ? '0 : mem_rdata;
                            rlast_q  <= ((rd_cnt_q + 4'd1) == rd_len_q);
                        end
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            unique case (wr_state_q)
                WR_IDLE: begin
                    if (s_awvalid_i) begin
                        wr_state_q <= WR_DATA;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        bid_q      <= s_awid_i;
                        wr_idx_q   <= aw_idx;
                        wr_len_q   <= s_awlen_i;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= aw_err;
                    end
                end
                WR_DATA: begin
                    if (s_wvalid_i) begin
                        wr_err_q <= w_err;
                        wr_idx_q <= wr_idx_q + MEM_AW'(1);
                        wr_cnt_q <= wr_cnt_q + 4'd1;
                        if (w_last_exp) begin
                            wr_state_q <= WR_RESP;
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bresp_q    <= w_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_bready_i) begin
                        wr_state_q <= WR_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    assign s_arready_o = arready_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rid_o     = rid_q;
    assign s_rdata_o   = rdata_q;
    assign s_rresp_o   = rresp_q;
    assign s_rlast_o   = rlast_q;
    assign s_awready_o = awready_q;
    assign s_wready_o  = wready_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_bid_o     = bid_q;
    assign s_bresp_o   = bresp_q;

endmodule

// File: tb/tb_bank_axi3_mem_slave.sv
// Self-checking bench: table-driven bursts, hand sequences for stall/collision and
// reset, then random bursts checked against a line-array reference model.
module tb_bank_axi3_mem_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [7:0]   s_arid, s_rid, s_awid, s_wid, s_bid;
    logic [31:0]  s_araddr, s_awaddr, s_wstrb;
    logic [2:0]   s_arsize, s_awsize;
    logic [3:0]   s_arlen, s_awlen;
    logic [1:0]   s_arburst, s_awburst, s_rresp, s_bresp;
    logic [255:0] s_rdata, s_wdata;
    logic         s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
    logic         s_bvalid, s_bready;

    int n_checks = 0;
    int n_errors = 0;

    logic [255:0] model_mem [64];
    logic [255:0] wbuf_data [16];
    logic [31:0]  wbuf_strb [16];

    always #5 clk = ~clk;

    bank_axi3_mem_slave dut (
        .clk_i(clk), .rst_i(rst),
        .s_arvalid_i(s_arvalid), .s_arready_o(s_arready), .s_arid_i(s_arid),
        .s_araddr_i(s_araddr), .s_arsize_i(s_arsize), .s_arlen_i(s_arlen),
        .s_arburst_i(s_arburst),
        .s_rvalid_o(s_rvalid), .s_rready_i(s_rready), .s_rid_o(s_rid), .s_rdata_o(s_rdata),
        .s_rresp_o(s_rresp), .s_rlast_o(s_rlast),
        .s_awvalid_i(s_awvalid), .s_awready_o(s_awready), .s_awid_i(s_awid),
        .s_awaddr_i(s_awaddr), .s_awsize_i(s_awsize), .s_awlen_i(s_awlen),
        .s_awburst_i(s_awburst),
        .s_wvalid_i(s_wvalid), .s_wready_o(s_wready), .s_wid_i(s_wid), .s_wdata_i(s_wdata),
        .s_wstrb_i(s_wstrb), .s_wlast_i(s_wlast),
        .s_bvalid_o(s_bvalid), .s_bready_i(s_bready), .s_bid_o(s_bid), .s_bresp_o(s_bresp)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          bad_beat;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == 3'b101) && (burst == 2'b01);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] id, input int bad_beat,
                            input logic [1:0] exp_bresp);
        logic [5:0] idx;
        logic       err;
        int         n;
        s_awvalid = 1'b1; s_awaddr = addr; s_awlen = len; s_awsize = size;
        s_awburst = burst; s_awid = id;
        n = 0;
        while (!s_awready && n < 20) begin step(); n++; end
        chk("aw_ready", s_awready, 1'b1);
        step();
        s_awvalid = 1'b0;
        idx = addr[10:5];
        err = !is_legal(size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            s_wvalid = 1'b1;
            s_wdata  = wbuf_data[b];
            s_wstrb  = wbuf_strb[b];
            s_wlast  = (b == int'(len)) ^ (b == bad_beat);
            s_wid    = 8'($urandom());
            n = 0;
            while (!s_wready && n < 20) begin step(); n++; end
            chk("w_ready", s_wready, 1'b1);
            if (s_wlast != (b == int'(len))) err = 1'b1;
            if (!err) begin
                for (int k = 0; k < 32; k++)
                    if (wbuf_strb[b][k]) model_mem[idx][k*8 +: 8] = wbuf_data[b][k*8 +: 8];
            end
            idx++;
            step();
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
        repeat ($urandom_range(0, 2)) step();
        s_bready = 1'b1;
        n = 0;
        while (!s_bvalid && n < 20) begin step(); n++; end
        chk("b_valid", s_bvalid, 1'b1);
        chk("b_resp", s_bresp, exp_bresp);
        chk("b_id", s_bid, id);
        step();
        s_bready = 1'b0;
        chk("b_done", s_bvalid, 1'b0);
        chk("aw_ready_after_b", s_awready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [7:0] id, input logic [1:0] exp_rresp,
                           input logic stall);
        logic [5:0]   idx;
        logic [255:0] exp_data;
        int           n, stalls;
        s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arsize = size;
        s_arburst = burst; s_arid = id;
        n = 0;
        while (!s_arready && n < 20) begin step(); n++; end
        chk("ar_ready", s_arready, 1'b1);
        step();
        s_arvalid = 1'b0;
        chk("r_first_latency", s_rvalid, 1'b1);
        idx = addr[10:5];
        for (int b = 0; b <= int'(len); b++) begin
            exp_data = is_legal(size, burst) ? model_mem[idx] : '0;
            stalls = stall ? $urandom_range(0, 2) : 0;
            for (int s = 0; s <= stalls; s++) begin
                s_rready = (s == stalls);
                chk("r_valid", s_rvalid, 1'b1);
                chk("r_data", s_rdata, exp_data);
                chk("r_id", s_rid, id);
                chk("r_resp", s_rresp, exp_rresp);
                chk("r_last", s_rlast, (b == int'(len)));
                step();
            end
            idx++;
        end
        s_rready = 1'b0;
        chk("r_done", s_rvalid, 1'b0);
        chk("ar_ready_after_r", s_arready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] held;
        logic [31:0]  addr;
        logic [3:0]   len, rlen;
        logic [2:0]   size;
        logic [1:0]   burst;
        logic         legal;
        int           bad;

        vecs[0] = '{"single_a5",   32'h0000_0040, 4'd0, 3'b101, 2'b01, -1, OKAY,   OKAY};
        vecs[1] = '{"wrap_4beat",  32'h0000_07E0, 4'd3, 3'b101, 2'b01, -1, OKAY,   OKAY};
        vecs[2] = '{"bad_size",    32'h0000_0300, 4'd2, 3'b100, 2'b01, -1, SLVERR, SLVERR};
        vecs[3] = '{"bad_burst",   32'hFFFF_F320, 4'd1, 3'b101, 2'b10, -1, SLVERR, SLVERR};
        vecs[4] = '{"early_wlast", 32'h0000_0500, 4'd2, 3'b101, 2'b01,  1, SLVERR, OKAY};

        rst = 1'b1;
        s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arsize = 0; s_arlen = 0; s_arburst = 0;
        s_rready = 0;
        s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awsize = 0; s_awlen = 0; s_awburst = 0;
        s_wvalid = 0; s_wid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
        #2;
        chk("rst_arready", s_arready, 1'b1);
        chk("rst_awready", s_awready, 1'b1);
        chk("rst_wready", s_wready, 1'b0);
        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_rlast", s_rlast, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_rid_bid", {s_rid, s_bid}, 16'h0);
        chk("rst_resps", {s_rresp, s_bresp}, 4'h0);
        chk("rst_rdata", s_rdata, '0);
        step(); step();
        rst = 1'b0;
        step();

        // Fill every line so the model is fully defined.
        for (int blk = 0; blk < 4; blk++) begin
            for (int b = 0; b < 16; b++) begin
                wbuf_data[b] = rand_line();
                wbuf_strb[b] = 32'hFFFF_FFFF;
            end
            do_write(32'(blk * 16 * 32), 4'd15, 3'b101, 2'b01, 8'(blk), -1, OKAY);
        end

        foreach (vecs[i]) begin
            for (int b = 0; b < 16; b++) begin
                wbuf_strb[b] = 32'hFFFF_FFFF;
                if (i == 0)      wbuf_data[b] = {32{8'hA5}};
                else if (i == 1) wbuf_data[b] = 256'(b + 1);
                else             wbuf_data[b] = rand_line();
            end
            do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 8'(8'h10 + i),
                     vecs[i].bad_beat, vecs[i].exp_bresp);
            do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst, 8'(8'h20 + i),
                    vecs[i].exp_rresp, 1'b1);
        end
        // Partially written lines read back through legal bursts too.
        do_read(32'h0000_0300, 4'd2, 3'b101, 2'b01, 8'h31, OKAY, 1'b0);
        do_read(32'h0000_0500, 4'd2, 3'b101, 2'b01, 8'h32, OKAY, 1'b0);

        // Partial strobe over an all-ones line.
        wbuf_data[0] = {32{8'hFF}};
        wbuf_strb[0] = 32'hFFFF_FFFF;
        do_write(32'h0000_0140, 4'd0, 3'b101, 2'b01, 8'h40, -1, OKAY);
        wbuf_data[0] = '0;
        wbuf_strb[0] = 32'h0000_000F;
        do_write(32'h0000_0140, 4'd0, 3'b101, 2'b01, 8'h41, -1, OKAY);
        do_read(32'h0000_0140, 4'd0, 3'b101, 2'b01, 8'h42, OKAY, 1'b0);

        // Stall a read beat while the same line is overwritten; the held beat must not change.
        s_arvalid = 1'b1; s_araddr = 32'h0000_00A0; s_arlen = 4'd1; s_arsize = 3'b101;
        s_arburst = 2'b01; s_arid = 8'h55;
        step();
        s_arvalid = 1'b0;
        held = model_mem[5];
        wbuf_data[0] = rand_line();
        for (int c = 0; c < 5; c++) begin
            s_rready = 1'b0;
            chk("stall_rvalid", s_rvalid, 1'b1);
            chk("stall_rdata", s_rdata, held);
            chk("stall_rid", s_rid, 8'h55);
            chk("stall_rlast", s_rlast, 1'b0);
            s_awvalid = (c == 0); s_awaddr = 32'h0000_00A0; s_awlen = 4'd0; s_awid = 8'h66;
            s_awsize = 3'b101; s_awburst = 2'b01;
            s_wvalid = (c == 1); s_wlast = (c == 1); s_wdata = wbuf_data[0];
            s_wstrb = 32'hFFFF_FFFF;
            s_bready = (c == 2);
            if (c == 2) begin
                chk("stall_bvalid", s_bvalid, 1'b1);
                chk("stall_bresp", s_bresp, OKAY);
                chk("stall_bid", s_bid, 8'h66);
            end
            step();
        end
        s_awvalid = 0; s_wvalid = 0; s_wlast = 0; s_bready = 0;
        model_mem[5] = wbuf_data[0];
        s_rready = 1'b1;
        chk("stall_rdata_release", s_rdata, held);
        step();
        chk("stall_beat1_data", s_rdata, model_mem[6]);
        chk("stall_beat1_last", s_rlast, 1'b1);
        step();
        s_rready = 1'b0;
        chk("stall_done", s_rvalid, 1'b0);
        do_read(32'h0000_00A0, 4'd0, 3'b101, 2'b01, 8'h56, OKAY, 1'b0);

        // Reset in the middle of a read burst.
        s_arvalid = 1'b1; s_araddr = 32'h0000_0100; s_arlen = 4'd3; s_arsize = 3'b101;
        s_arburst = 2'b01; s_arid = 8'h77;
        step();
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        step(); step();
        s_rready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_rvalid", s_rvalid, 1'b0);
        chk("rst_mid_arready", s_arready, 1'b1);
        chk("rst_mid_rlast", s_rlast, 1'b0);
        step();
        rst = 1'b0;
        step();
        do_read(32'h0000_0100, 4'd1, 3'b101, 2'b01, 8'h78, OKAY, 1'b1);

        // Random bursts against the line-array model.
        for (int it = 0; it < 25; it++) begin
            addr  = $urandom();
            len   = 4'($urandom_range(0, 15));
            legal = ($urandom_range(0, 7) != 0);
            size  = 3'b101;
            burst = 2'b01;
            if (!legal) begin
                if ($urandom_range(0, 1) == 1) size = 3'($urandom_range(0, 4));
                else burst = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(2, 3));
            end
            bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
            for (int b = 0; b < 16; b++) begin
                wbuf_data[b] = rand_line();
                wbuf_strb[b] = $urandom();
            end
            do_write(addr, len, size, burst, 8'($urandom()), bad,
                     (!legal || bad >= 0) ? SLVERR : OKAY);
            rlen  = 4'($urandom_range(0, 15));
            legal = ($urandom_range(0, 7) != 0);
            size  = legal ? 3'b101 : 3'b010;
            do_read(addr, rlen, size, 2'b01, 8'($urandom()), legal ? OKAY : SLVERR, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
